// File: rtl/mul_seq.sv
// Iterative 8x8 shift-add multiplier for MUL/MULS/MULSU/FMUL/FMULS/FMULSU.
// One partial product per clock over 8 iterations; result and flags are registered on the last one.
module mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cf,
  output logic        zf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic [15:0] acc_reg;
  logic [15:0] mcand_reg;
  logic [7:0]  mplier_reg;
  logic        b_signed_reg;
  logic        frac_reg;
  logic [15:0] result_reg;
  logic        cf_reg;
  logic        zf_reg;

  logic [15:0] pp [8];
  logic [15:0] partial;
  logic [15:0] acc_next;
  logic [15:0] prod_out;
  logic        a_signed;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign pp[gi] = mcand_reg << gi;
    end
  endgenerate

  // Reserved op[1:0]=11 falls through to the unsigned path.
  assign a_signed = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);

  always_comb begin
    partial  = pp[cnt_reg];
    acc_next = acc_reg;
    if (mplier_reg[cnt_reg]) begin
      // Bit 7 of a signed multiplier carries weight -2^7.
      if (cnt_reg == 3'd7 && b_signed_reg)
        acc_next = acc_reg - partial;
      else
        acc_next = acc_reg + partial;
    end
    prod_out = frac_reg ? {acc_next[14:0], 1'b0} : acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 3'd0;
      acc_reg      <= 16'h0000;
      mcand_reg    <= 16'h0000;
      mplier_reg   <= 8'h00;
      b_signed_reg <= 1'b0;
      frac_reg     <= 1'b0;
      result_reg   <= 16'h0000;
      cf_reg       <= 1'b0;
      zf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mcand_reg    <= a_signed ? {{8{a[7]}}, a} : {8'h00, a};
            mplier_reg   <= b;
            b_signed_reg <= (op[1:0] == 2'b01);
            frac_reg     <= op[2];
            acc_reg      <= 16'h0000;
            cnt_reg      <= 3'd0;
            state_reg    <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          if (cnt_reg == 3'd7) begin
            result_reg <= prod_out;
            cf_reg     <= acc_next[15];
            zf_reg     <= (prod_out == 16'h0000);
            state_reg  <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == ST_RUN);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign cf     = cf_reg;
  assign zf     = zf_reg;

endmodule
